// File: rtl/traffic_pkg.sv
// Shared lamp encodings, state enum and timer width for the traffic light controller.
// Lamps are one-hot {red, yellow, green}; states pair each approach's green with its yellow.
package traffic_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    localparam int CNT_W = 8;

    // Bit 0 selects yellow, bits [2:1] select the approach (N, S, E, W).
    typedef enum logic [2:0] {
        N_G = 3'd0,
        N_Y = 3'd1,
        S_G = 3'd2,
        S_Y = 3'd3,
        E_G = 3'd4,
        E_Y = 3'd5,
        W_G = 3'd6,
        W_Y = 3'd7
    } state_e;

    function automatic logic [2:0] lamp_for(input state_e st, input logic [1:0] approach);
        logic [2:0] lamp;
        lamp = RED;
        if (st[2:1] == approach) begin
            lamp = st[0] ? YELLOW : GREEN;
        end
        return lamp;
    endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Phase timer: counts cycles in the current phase and flags the last one.
// A count at or beyond the final value also expires, so a corrupted count recovers in one edge.
module traffic_phase_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dur_i,
    output logic             expire_o
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] last;

    always_comb begin
        last     = dur_i - WIDTH'(1);
        expire_o = (cnt >= last);
        cnt_d    = expire_o ? '0 : cnt + WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic.sv
// Fixed-time four-way traffic light controller: N -> S -> E -> W, each green then yellow.
// Moore outputs decoded from the state register; the phase timer decides when to advance.
module traffic
    import traffic_pkg::*;
#(
    parameter int GREEN_CYCLES  = 4,
    parameter int YELLOW_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] n,
    output logic [2:0] s,
    output logic [2:0] e,
    output logic [2:0] w
);

    state_e           st;
    state_e           st_d;
    logic [CNT_W-1:0] dur;
    logic             expire;

    always_comb begin
        dur = st[0] ? CNT_W'(YELLOW_CYCLES) : CNT_W'(GREEN_CYCLES);
    end

    traffic_phase_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .dur_i    (dur),
        .expire_o (expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st <= N_G;
        end else begin
            st <= st_d;
        end
    end

    // All eight codes are live, so the rotation is a plain wrap-around increment.
    always_comb begin
        st_d = st;
        if (expire) begin
            st_d = state_e'(3'(st + 3'd1));
        end
    end

    always_comb begin
        n = lamp_for(st, 2'd0);
        s = lamp_for(st, 2'd1);
        e = lamp_for(st, 2'd2);
        w = lamp_for(st, 2'd3);
    end

endmodule

// File: tb/tb_traffic.sv
// Bench for traffic: three instances (default, 1/1, 10/3 durations) share clock and reset,
// and every cycle is compared with a timing model computed from elapsed edges since reset release.
module tb_traffic;

    localparam logic [2:0] L_RED    = 3'b100;
    localparam logic [2:0] L_YELLOW = 3'b010;
    localparam logic [2:0] L_GREEN  = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] n0, s0, e0, w0;
    logic [2:0] n1, s1, e1, w1;
    logic [2:0] n2, s2, e2, w2;

    int checks = 0;
    int errors = 0;
    int t      = 0;

    logic [2:0] prev_lamp [3][4];
    logic       prev_ok   [3];

    traffic u_def (
        .clk (clk), .rst (rst), .n (n0), .s (s0), .e (e0), .w (w0)
    );

    traffic #(.GREEN_CYCLES(1), .YELLOW_CYCLES(1)) u_fast (
        .clk (clk), .rst (rst), .n (n1), .s (s1), .e (e1), .w (w1)
    );

    traffic #(.GREEN_CYCLES(10), .YELLOW_CYCLES(3)) u_slow (
        .clk (clk), .rst (rst), .n (n2), .s (s2), .e (e2), .w (w2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: position within the rotation picks the approach and whether it is past its green time.
    task automatic check_dut(input int id, input int g, input int y,
                             input logic [2:0] st_obs,
                             input logic [2:0] ln, input logic [2:0] ls,
                             input logic [2:0] le, input logic [2:0] lw);
        logic [2:0] lamps [4];
        logic [2:0] exp_lamp;
        int pos, approach, in_phase, yellow, nonred;
        logic ok;
        lamps    = '{ln, ls, le, lw};
        pos      = t % (4 * (g + y));
        approach = pos / (g + y);
        in_phase = pos % (g + y);
        yellow   = (in_phase >= g) ? 1 : 0;
        check($sformatf("dut%0d st t=%0d", id, t), {29'd0, st_obs}, 32'(approach * 2 + yellow));
        nonred = 0;
        for (int i = 0; i < 4; i++) begin
            exp_lamp = (i != approach) ? L_RED : (yellow != 0 ? L_YELLOW : L_GREEN);
            check($sformatf("dut%0d lamp%0d t=%0d", id, i, t), {29'd0, lamps[i]}, {29'd0, exp_lamp});
            check($sformatf("dut%0d onehot%0d", id, i), 32'($countones(lamps[i])), 32'd1);
            if (lamps[i] != L_RED) nonred++;
            if (prev_ok[id]) begin
                ok = !((prev_lamp[id][i] == L_YELLOW) && (lamps[i] == L_GREEN)) &&
                     !((prev_lamp[id][i] == L_RED) && (lamps[i] == L_YELLOW));
                check($sformatf("dut%0d seq%0d t=%0d", id, i, t), {31'd0, ok}, 32'd1);
            end
            prev_lamp[id][i] = lamps[i];
        end
        prev_ok[id] = 1'b1;
        check($sformatf("dut%0d nonred t=%0d", id, t), {31'd0, (nonred <= 1)}, 32'd1);
    endtask

    task automatic check_all();
        check_dut(0, 4, 2, u_def.st, n0, s0, e0, w0);
        check_dut(1, 1, 1, u_fast.st, n1, s1, e1, w1);
        check_dut(2, 10, 3, u_slow.st, n2, s2, e2, w2);
    endtask

    task automatic clear_history();
        for (int d = 0; d < 3; d++) prev_ok[d] = 1'b0;
    endtask

    task automatic run_edges(input int k);
        repeat (k) begin
            @(posedge clk);
            if (rst) t++;
            @(negedge clk);
            check_all();
        end
    endtask

    // Assert reset part-way through a low clock phase and check the outputs before any edge.
    task automatic mid_reset(input int offset);
        #(offset);
        rst = 1'b0;
        t   = 0;
        clear_history();
        #1;
        check_all();
        @(negedge clk);
        check_all();
        rst = 1'b1;
    endtask

    initial begin
        clear_history();
        @(negedge clk);
        mid_reset(3);

        // First rotation with explicit spot checks on the documented edge numbers.
        for (int k = 1; k <= 24; k++) begin
            run_edges(1);
            if (t == 4)  check("edge4 n",  {29'd0, n0}, {29'd0, L_YELLOW});
            if (t == 6)  check("edge6 s",  {29'd0, s0}, {29'd0, L_GREEN});
            if (t == 13) check("slow edge13 s", {29'd0, s2}, {29'd0, L_GREEN});
            if (t == 18) check("edge18 w", {29'd0, w0}, {29'd0, L_GREEN});
            if (t == 8)  check("fast edge8 st", {29'd0, u_fast.st}, 32'd0);
        end

        run_edges(72);

        // Land in E_Y with one yellow edge already counted, then reset.
        run_edges(17);
        check("pre-reset E_Y", {29'd0, u_def.st}, 32'd5);
        mid_reset(2);
        run_edges(3);
        check("post-reset still N_G", {29'd0, u_def.st}, 32'd0);
        run_edges(1);
        check("post-reset N_Y at edge4", {29'd0, u_def.st}, 32'd1);

        for (int k = 0; k < 6; k++) begin
            run_edges($urandom_range(1, 60));
            mid_reset($urandom_range(1, 3));
        end
        run_edges(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic.md
Name: traffic

Overview:
- Fixed-time, four-way traffic light controller for a single intersection.
- Approaches are North, South, East and West. Each gets green, then yellow, in round-robin order N -> S -> E -> W -> N.
- While one approach is green or yellow, the other three are held red.
- Standalone Moore FSM with an internal phase timer; it has no external inputs other than clock and reset.

Parameters:
- GREEN_CYCLES, 4: clock cycles each approach stays green. Legal range 1..255.
- YELLOW_CYCLES, 2: clock cycles each approach stays yellow. Legal range 1..255.

Ports:
- clk, input, 1: system clock; all state changes on the rising edge.
- rst, input, 1: asynchronous, active-low reset. 0 = reset asserted.
- n, output, 3: North lamp, encoded {red, yellow, green}.
- s, output, 3: South lamp, same encoding.
- e, output, 3: East lamp, same encoding.
- w, output, 3: West lamp, same encoding.

Behaviour:
- Lamp encoding (exactly one bit set at all times):
  - RED = 3'b100
  - YELLOW = 3'b010
  - GREEN = 3'b001
- One clock; reset is asynchronous and active-low.
- State register `st` is 3 bits, binary encoded, and must keep that internal name so benches can probe it hierarchically:
  - N_G = 0, N_Y = 1
  - S_G = 2, S_Y = 3
  - E_G = 4, E_Y = 5
  - W_G = 6, W_Y = 7
- Transitions: N_G -> N_Y -> S_G -> S_Y -> E_G -> E_Y -> W_G -> W_Y -> N_G.
  - Next state is always st+1 modulo 8, but only when the phase timer expires.
- Phase timer: 8-bit counter `cnt`.
  - In a *_G state it expires when cnt == GREEN_CYCLES-1.
  - In a *_Y state it expires when cnt == YELLOW_CYCLES-1.
  - On expiry: st advances and cnt clears to 0. Otherwise cnt increments and st holds.
- Each green phase therefore lasts exactly GREEN_CYCLES rising edges, and each yellow phase exactly YELLOW_CYCLES. One full rotation is 4*(GREEN_CYCLES+YELLOW_CYCLES) cycles (24 with defaults).
- Outputs are a pure combinational decode of st (Moore), so they change in the same cycle st changes:
  - Active approach = GREEN in *_G, YELLOW in *_Y.
  - All other approaches = RED.
- Reset (rst = 0):
  - Immediately, without waiting for a clock edge: st = N_G, cnt = 0, n = GREEN, s = e = w = RED.
  - Held for as long as rst = 0.
- Reset release: the first rising edge with rst = 1 counts as green cycle 1 of N_G.
- Reset asserted mid-phase (any state, any cnt): immediate return to the reset values above. The partial phase is discarded.
- Safety invariants, which must hold in every cycle including during reset:
  - At most one approach is non-RED.
  - No approach ever goes GREEN directly after YELLOW, and none goes YELLOW without a preceding GREEN phase.
- Unreachable st values cannot occur (all 8 codes are used). cnt must never exceed the max duration minus 1. Any out-of-range cnt must clear to 0 and advance on the next edge.
- Durations of 1 are legal: the phase lasts one cycle.

Decomposition:
- Package traffic_pkg holds:
  - the light constants RED/YELLOW/GREEN (3-bit);
  - the state enum (N_G..W_Y, 3-bit), with the encoding above.
- The phase timer is a natural sub-module, traffic_phase_timer. It takes clk, rst, a load-duration input and an expire output, and is parameterised by width (8).
- Top-level traffic contains the state register, next-state logic and lamp decoder.

Test Plan:
1. Hold rst = 0 for 1 cycle, including mid-cycle assertion -> immediately n = 001, s = e = w = 100, st = 0. The values must hold without any clock edge.
2. Release rst; with defaults, count edges -> transitions at these edge numbers:
   - 4: st = 1, n = 010
   - 6: st = 2, n = 100, s = 001
   - 10: st = 3
   - 12: st = 4, e = 001
   - 16: st = 5
   - 18: st = 6, w = 001
   - 22: st = 7, w = 010
   - 24: st = 0, n = 001
3. Run 3 full rotations (72 cycles) with a per-cycle checker -> never more than one non-RED output, and every lamp value is one-hot.
4. Assert rst for 1 cycle while in E_Y at cnt = 1 -> immediate st = 0, n = 001. After release, N_Y is entered exactly 4 edges later.
5. Instantiate with GREEN_CYCLES = 1, YELLOW_CYCLES = 1 -> st increments on every edge, 0..7 then wraps to 0 on edge 8.
6. Instantiate with GREEN_CYCLES = 10, YELLOW_CYCLES = 3 -> the N green phase lasts exactly 10 edges and N yellow exactly 3. S becomes green on edge 13.
